// File: rtl/scoreboard_sequencer.sv
// Scoreboard sequencer: tracks the occupancy of an external FIFO under test.
// It captures one "magic" packet after a programmable number of accepted
// pushes, then follows that packet's position until it leaves the FIFO.
// On exit it checks that the departing data matches the captured value.
module scoreboard_sequencer #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 8,
    parameter int SKIPWID = 8,
    parameter int CNTWID  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               rearm,
    input  logic [SKIPWID-1:0] skip,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH-1:0]   data_out,
    output logic               start,
    output logic               data_out_vld,
    output logic               prop_signal,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_TRACK,
        S_DONE
    } state_t;

    localparam logic [CNTWID-1:0] DEPTH_C = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] ONE_C   = CNTWID'(1);

    state_t             state;
    logic [CNTWID-1:0]  occ;
    logic [CNTWID-1:0]  trk;
    logic [SKIPWID-1:0] scnt;
    logic [WIDTH-1:0]   magic;

    logic acc_push;
    logic acc_pop;
    logic overflow;
    logic underflow;
    logic magic_match;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign acc_push  = push & ((occ < DEPTH_C) | pop);
    assign acc_pop   = pop & (occ != '0);
    assign overflow  = push & ~acc_push;
    assign underflow = pop & ~acc_pop;

    assign magic_match  = (data_out == magic);
    assign start        = (state == S_ARM) & acc_push & (scnt == skip);
    assign data_out_vld = (state == S_TRACK) & acc_pop & (trk == ONE_C);
    assign prop_signal  = ~data_out_vld | magic_match;
    assign busy         = (state == S_ARM) | (state == S_TRACK);
    assign done         = (state == S_DONE);

    // Occupancy follows the FIFO in every state; illegal traffic leaves it unchanged and sets the sticky error.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            occ <= '0;
            err <= 1'b0;
        end else begin
            occ <= occ + {{(CNTWID-1){1'b0}}, acc_push} - {{(CNTWID-1){1'b0}}, acc_pop};
            if (overflow | underflow) begin
                err <= 1'b1;
            end
        end
    end

    // Round sequencing: skip counting in ARM, position tracking in TRACK, result held in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            scnt  <= '0;
            trk   <= '0;
            magic <= '0;
            pass  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        state <= S_ARM;
                        scnt  <= '0;
                    end
                end
                S_ARM: begin
                    if (start) begin
                        magic <= data_in;
                        // Position of the captured packet once this cycle's pop has left.
                        trk   <= occ - {{(CNTWID-1){1'b0}}, acc_pop} + ONE_C;
                        state <= S_TRACK;
                    end else if (acc_push && (scnt != '1)) begin
                        scnt <= scnt + 1'b1;
                    end
                end
                S_TRACK: begin
                    if (acc_pop) begin
                        trk <= trk - ONE_C;
                        if (trk == ONE_C) begin
                            pass  <= magic_match;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (rearm) begin
                        state <= S_ARM;
                        scnt  <= '0;
                        pass  <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scoreboard_sequencer.sv
// Self-checking bench for scoreboard_sequencer: a queue-based model tracks
// the FIFO contents and which entry is the magic packet; a compare process
// checks every output on each falling edge, and directed steps pin
// hand-computed values.
module tb_scoreboard_sequencer;

    localparam int DEPTH   = 8;
    localparam int WIDTH   = 8;
    localparam int SKIPWID = 8;

    localparam int P_IDLE  = 0;
    localparam int P_ARM   = 1;
    localparam int P_TRACK = 2;
    localparam int P_DONE  = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               go = 1'b0;
    logic               rearm = 1'b0;
    logic [SKIPWID-1:0] skip = '0;
    logic               push = 1'b0;
    logic               pop = 1'b0;
    logic [WIDTH-1:0]   data_in = '0;
    logic [WIDTH-1:0]   data_out = '0;
    logic start, data_out_vld, prop_signal, busy, done, pass, err;

    int errors = 0;
    int checks = 0;

    scoreboard_sequencer #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .SKIPWID(SKIPWID)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .rearm(rearm), .skip(skip),
        .push(push), .pop(pop), .data_in(data_in), .data_out(data_out),
        .start(start), .data_out_vld(data_out_vld), .prop_signal(prop_signal),
        .busy(busy), .done(done), .pass(pass), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO contents as a queue of "is magic" marks plus the round phase.
    bit               q[$];
    int               m_phase = P_IDLE;
    int               m_cnt = 0;
    logic [WIDTH-1:0] m_magic = '0;
    bit               m_pass = 1'b0;
    bit               m_err = 1'b0;

    function automatic bit m_apush();
        return push && ((q.size() < DEPTH) || pop);
    endfunction

    function automatic bit m_apop();
        return pop && (q.size() != 0);
    endfunction

    function automatic bit m_start();
        return (m_phase == P_ARM) && m_apush() && (m_cnt == int'(skip));
    endfunction

    function automatic bit m_vld();
        return (m_phase == P_TRACK) && m_apop() && q[0];
    endfunction

    always @(posedge clk or negedge rst) begin : model_update
        bit ap, apo, st, vl;
        if (!rst) begin
            q.delete();
            m_phase = P_IDLE;
            m_cnt   = 0;
            m_magic = '0;
            m_pass  = 1'b0;
            m_err   = 1'b0;
        end else begin
            ap  = m_apush();
            apo = m_apop();
            st  = m_start();
            vl  = m_vld();
            if ((push && !ap) || (pop && !apo)) m_err = 1'b1;
            if (apo) void'(q.pop_front());
            if (ap) q.push_back(st);
            case (m_phase)
                P_IDLE:  if (go) begin m_phase = P_ARM; m_cnt = 0; end
                P_ARM:   if (st) begin m_magic = data_in; m_phase = P_TRACK; end
                         else if (ap) m_cnt++;
                P_TRACK: if (vl) begin m_pass = (data_out == m_magic); m_phase = P_DONE; end
                P_DONE:  if (rearm) begin m_phase = P_ARM; m_cnt = 0; m_pass = 1'b0; end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Compare every output against the model away from the rising edge.
    always @(negedge clk) begin
        check("start", start, m_start());
        check("data_out_vld", data_out_vld, m_vld());
        check("prop_signal", prop_signal, !m_vld() || (data_out == m_magic));
        check("busy", busy, (m_phase == P_ARM) || (m_phase == P_TRACK));
        check("done", done, m_phase == P_DONE);
        check("pass", pass, m_pass);
        check("err", err, m_err);
        check("occ", 32'(dut.occ), q.size());
    end

    task automatic apply(input logic g, input logic r, input logic [SKIPWID-1:0] s,
                         input logic pu, input logic po,
                         input logic [WIDTH-1:0] di, input logic [WIDTH-1:0] dq);
        go = g; rearm = r; skip = s; push = pu; pop = po; data_in = di; data_out = dq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #10;
        check("rst start", start, 0);
        check("rst vld", data_out_vld, 0);
        check("rst prop", prop_signal, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst pass", pass, 0);
        check("rst err", err, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // skip=2: capture the third push, release on the third pop with matching data
        apply(1, 0, 2, 0, 0, 8'h00, 8'h00); tick();
        check("A busy after go", busy, 1);
        apply(0, 0, 2, 1, 0, 8'h11, 8'h00); check("A start push1", start, 0); tick();
        apply(0, 0, 2, 1, 0, 8'h22, 8'h00); check("A start push2", start, 0); tick();
        apply(0, 0, 2, 1, 0, 8'h33, 8'h00); check("A start push3", start, 1); tick();
        check("A magic", 32'(dut.magic), 32'h33);
        check("A trk", 32'(dut.trk), 3);
        apply(0, 0, 2, 0, 1, 8'h00, 8'h11); check("A vld pop1", data_out_vld, 0); tick();
        apply(0, 0, 2, 0, 1, 8'h00, 8'h22); check("A vld pop2", data_out_vld, 0); tick();
        apply(0, 0, 2, 0, 1, 8'h00, 8'h33);
        check("A vld pop3", data_out_vld, 1);
        check("A prop pop3", prop_signal, 1);
        tick();
        check("A done", done, 1);
        check("A pass", pass, 1);
        apply(1, 0, 2, 0, 0, 8'h00, 8'h00); tick();
        check("A go ignored in DONE", done, 1);

        // same round with a corrupted third packet
        apply(0, 1, 2, 0, 0, 8'h00, 8'h00); tick();
        check("B busy after rearm", busy, 1);
        check("B pass cleared", pass, 0);
        apply(0, 0, 2, 1, 0, 8'h44, 8'h00); tick();
        apply(0, 0, 2, 1, 0, 8'h55, 8'h00); tick();
        apply(0, 0, 2, 1, 0, 8'h66, 8'h00); check("B start push3", start, 1); tick();
        apply(0, 0, 2, 0, 1, 8'h00, 8'h44); tick();
        apply(0, 0, 2, 0, 1, 8'h00, 8'h55); tick();
        apply(0, 0, 2, 0, 1, 8'h00, 8'h34);
        check("B vld pop3", data_out_vld, 1);
        check("B prop mismatch", prop_signal, 0);
        tick();
        check("B done", done, 1);
        check("B pass", pass, 0);

        // skip=0 at occ=2 with a pop in the capture cycle
        apply(0, 0, 0, 1, 0, 8'hA1, 8'h00); tick();
        apply(0, 0, 0, 1, 0, 8'hA2, 8'h00); tick();
        apply(0, 1, 0, 0, 0, 8'h00, 8'h00); tick();
        apply(0, 0, 0, 1, 1, 8'hA3, 8'hA1);
        check("C start", start, 1);
        check("C vld capture", data_out_vld, 0);
        tick();
        check("C trk", 32'(dut.trk), 2);
        apply(0, 0, 0, 0, 1, 8'h00, 8'hA2); check("C vld pop1", data_out_vld, 0); tick();
        apply(0, 0, 0, 0, 1, 8'h00, 8'hA3); check("C vld pop2", data_out_vld, 1); tick();
        check("C pass", pass, 1);

        // reset in the middle of TRACK
        apply(0, 1, 1, 0, 0, 8'h00, 8'h00); tick();
        apply(0, 0, 1, 1, 0, 8'hB1, 8'h00); tick();
        apply(0, 0, 1, 1, 0, 8'hB2, 8'h00); check("D start", start, 1); tick();
        check("D busy in TRACK", busy, 1);
        apply(0, 0, 1, 0, 0, 8'h00, 8'h00);
        #2 rst = 1'b0;
        #1;
        check("D rst busy", busy, 0);
        check("D rst done", done, 0);
        check("D rst start", start, 0);
        check("D rst vld", data_out_vld, 0);
        check("D rst prop", prop_signal, 1);
        check("D rst occ", 32'(dut.occ), 0);
        tick(); tick();
        rst = 1'b1;
        apply(0, 1, 0, 0, 0, 8'h00, 8'h00); tick();
        check("D rearm ignored busy", busy, 0);
        check("D rearm ignored done", done, 0);

        // go-cycle push only counts in occupancy; skip=0 captures the next push
        apply(1, 0, 0, 1, 0, 8'hC0, 8'h00); check("E start on go", start, 0); tick();
        check("E busy", busy, 1);
        apply(0, 0, 0, 1, 0, 8'hC1, 8'h00); check("E start", start, 1); tick();
        apply(0, 0, 0, 0, 1, 8'h00, 8'hC0); check("E vld pop1", data_out_vld, 0); tick();
        apply(0, 0, 0, 0, 1, 8'h00, 8'hC1); check("E vld pop2", data_out_vld, 1); tick();
        check("E pass", pass, 1);

        // underflow sets err
        apply(0, 0, 0, 0, 1, 8'h00, 8'h00); tick();
        check("F underflow err", err, 1);
        check("F still done", done, 1);

        // clear err, then overflow, full push+pop and drain
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("G err cleared", err, 0);
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, 0, 1, 0, 8'(i), 8'h00); tick();
        end
        check("G full no err", err, 0);
        check("G occ full", 32'(dut.occ), DEPTH);
        apply(0, 0, 0, 1, 0, 8'hFF, 8'h00); tick();
        check("G overflow err", err, 1);
        check("G occ held", 32'(dut.occ), DEPTH);
        apply(0, 0, 0, 1, 1, 8'hEE, 8'h00); tick();
        check("G push+pop at full", 32'(dut.occ), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 0, 0, 0, 1, 8'h00, 8'h00); tick();
        end
        check("G drained", 32'(dut.occ), 0);
        apply(0, 0, 0, 0, 1, 8'h00, 8'h00); tick();
        check("G err sticky", err, 1);
        check("G occ no wrap", 32'(dut.occ), 0);

        apply(0, 0, 0, 0, 0, 8'h00, 8'h00);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
